// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Each pipeline stage resolves NG/STAGES consecutive GROUP-bit lookahead
// groups, LSB first, rippling group carries within the stage and registering
// the carry into the next stage.
// Optional feature: define CLA_PIPE_SAT_EN to saturate the final sum on signed
// overflow (ovf and cout still report the unsaturated result).
module cla_pipe_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned GROUP  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NG  = WIDTH / GROUP;
  localparam int unsigned GPS = NG / STAGES;
  localparam int unsigned SB  = GPS * GROUP;

  // One lookahead group: returns {carry_out, sum}. Each carry is a flat
  // sum-of-products of generate/propagate terms and the group carry-in.
  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] ga,
                                               input logic [GROUP-1:0] gb,
                                               input logic             c0);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             pp;
    logic             cc;
    g    = ga & gb;
    p    = ga ^ gb;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < int'(GROUP); i++) begin
      cc = 1'b0;
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        cc = cc | (g[j] & pp);
        pp = pp & p[j];
      end
      c[i+1] = cc | (pp & c0);
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;

  // A stage advances when empty or when its successor advances.
  always_comb begin
    logic nxt;
    adv = '0;
    nxt = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      nxt    = !v[k] || nxt;
      adv[k] = nxt;
    end
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * SB;
    localparam int unsigned HI = LO + SB;

    // x carries finished sum bits below LO and untouched operand-A bits above.
    logic [WIDTH-1:0]  x_in;
    logic [WIDTH-1:0]  x_d;
    logic [WIDTH-1:0]  x_ld;
    logic [WIDTH-1:0]  x_q;
    logic [WIDTH-1:LO] y_in;
    logic              c_in;
    logic              c_d;
    logic              c_q;
    logic              v_in;
    logic              v_q;

    if (k == 0) begin : g_first
      assign x_in = a;
      assign y_in = b ^ {WIDTH{sub}};
      assign c_in = cin ^ sub;
      assign v_in = in_valid;
    end else begin : g_next
      assign x_in = g_stage[k-1].x_q;
      assign y_in = g_stage[k-1].g_mid.y_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
    end

    // Resolve this stage's groups, rippling the group carry.
    always_comb begin
      logic [GROUP:0] res;
      logic           c;
      x_d = x_in;
      c   = c_in;
      res = '0;
      for (int g = 0; g < int'(GPS); g++) begin
        res = cla_group(x_in[LO + g*GROUP +: GROUP], y_in[LO + g*GROUP +: GROUP], c);
        x_d[LO + g*GROUP +: GROUP] = res[GROUP-1:0];
        c = res[GROUP];
      end
      c_d = c;
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_d;
      logic ovf_q;

      assign ovf_d = (x_in[WIDTH-1] == y_in[WIDTH-1]) && (x_d[WIDTH-1] != x_in[WIDTH-1]);

`ifdef CLA_PIPE_SAT_EN
      // Clamp toward the sign of the operands when the signed result overflows.
      always_comb begin
        x_ld = x_d;
        if (ovf_d) begin
          x_ld = x_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end
`else
      assign x_ld = x_d;
`endif

      // Overflow flag register, loaded alongside the final sum.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv[k] && v_in) begin
          ovf_q <= ovf_d;
        end
      end
    end else begin : g_mid
      logic [WIDTH-1:HI] y_q;

      assign x_ld = x_d;

      // Remaining effective-B bits for the later stages.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_q <= '0;
        end else if (adv[k] && v_in) begin
          y_q <= y_in[WIDTH-1:HI];
        end
      end
    end

    // Stage valid, partial result and inter-stage carry.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        x_q <= '0;
        c_q <= 1'b0;
      end else if (adv[k]) begin
        v_q <= v_in;
        if (v_in) begin
          x_q <= x_ld;
          c_q <= c_d;
        end
      end
    end

    assign v[k] = v_q;
  end

  assign out_valid = v[STAGES-1];
  assign sum       = g_stage[STAGES-1].x_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule
